// File: rtl/uart_readout_scheduler_pkg.sv
// Shared constants, state encoding and sizing helper for the UART readout scheduler.
package uart_readout_scheduler_pkg;

  localparam logic [7:0] CMD_HIGH       = 8'h00;
  localparam logic [7:0] CMD_LOW        = 8'h01;
  localparam logic [7:0] CMD_PERIOD     = 8'h02;
  localparam logic [7:0] CMD_ALL        = 8'h03;
  localparam logic [7:0] CMD_STREAM_ON  = 8'h04;
  localparam logic [7:0] CMD_STREAM_OFF = 8'h05;
  localparam logic [7:0] TAG_STREAM     = 8'h83;
  localparam logic [7:0] TAG_ERR        = 8'hEE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_TAG,
    ST_DATA
  } state_t;

  // Payload bytes per measurement word.
  function automatic int unsigned nb(input int unsigned counter_bits,
                                     input int unsigned data_width);
    return counter_bits / data_width;
  endfunction

endpackage

// File: rtl/uart_readout_scheduler_if.sv
// Byte handshake between the scheduler and the UART RX/TX blocks.
interface uart_readout_scheduler_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/uart_readout_scheduler_cmd_fifo.sv
// Small synchronous command queue; first-word-fall-through read port.
module cmd_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  full,
  output logic                  empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end
endmodule

// File: rtl/uart_readout_scheduler.sv
// Decodes UART command bytes and streaming requests into framed measurement readouts
// (sync, tag, payload LSB-first) sent over a valid/ready byte handshake.
module uart_readout_scheduler
  import uart_readout_scheduler_pkg::*;
#(
  parameter int unsigned           COUNTER_BITS = 32,
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           FIFO_DEPTH   = 4,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE    = 8'hA5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  uart_readout_scheduler_if.slave uart,
  input  logic                    meas_valid,
  input  logic [COUNTER_BITS-1:0] time_high,
  input  logic [COUNTER_BITS-1:0] time_low,
  input  logic [COUNTER_BITS-1:0] period,
  output logic                    busy,
  output logic                    stream_en,
  output logic                    err_ovf
);
  localparam int unsigned NB    = nb(COUNTER_BITS, DATA_WIDTH);
  localparam int unsigned IDX_W = $clog2(3 * NB + 1);
  localparam int unsigned PW    = 3 * COUNTER_BITS;

  localparam logic [IDX_W-1:0] LEN_WORD = IDX_W'(NB);
  localparam logic [IDX_W-1:0] LEN_ALL  = IDX_W'(3 * NB);
  localparam logic [IDX_W-1:0] LEN_ERR  = IDX_W'(1);

  state_t state;
  state_t state_next;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_pop;

  logic                  stream_pend;
  logic [DATA_WIDTH-1:0] tag_q;
  logic [PW-1:0]         payload_q;
  logic [IDX_W-1:0]      remain_q;

  logic                  sel_cmd;
  logic                  sel_stream;
  logic                  select;
  logic [DATA_WIDTH-1:0] sel_tag;
  logic [IDX_W-1:0]      sel_len;
  logic [PW-1:0]         sel_payload;

  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;

  assign sel_cmd    = (state == ST_IDLE) && !fifo_empty;
  assign sel_stream = (state == ST_IDLE) && fifo_empty && stream_pend;
  assign select     = sel_cmd || sel_stream;
  assign fifo_pop   = sel_cmd;

  cmd_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (uart.rx_valid),
    .push_data (uart.rx_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame selection: stream frames and CMD_ALL share the all-words payload layout.
  always_comb begin
    sel_tag     = TAG_STREAM;
    sel_len     = LEN_ALL;
    sel_payload = {period, time_low, time_high};
    if (sel_cmd) begin
      sel_tag = fifo_head;
      case (fifo_head)
        CMD_HIGH: begin
          sel_len     = LEN_WORD;
          sel_payload = PW'(time_high);
        end
        CMD_LOW: begin
          sel_len     = LEN_WORD;
          sel_payload = PW'(time_low);
        end
        CMD_PERIOD: begin
          sel_len     = LEN_WORD;
          sel_payload = PW'(period);
        end
        CMD_ALL: ;
        CMD_STREAM_ON, CMD_STREAM_OFF: begin
          sel_len = '0;
        end
        default: begin
          sel_tag     = TAG_ERR;
          sel_len     = LEN_ERR;
          sel_payload = PW'(fifo_head);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (select) state_next = ST_SYNC;
      ST_SYNC: if (uart.tx_ready) state_next = ST_TAG;
      ST_TAG:  if (uart.tx_ready) state_next = (remain_q == '0) ? ST_IDLE : ST_DATA;
      ST_DATA: if (uart.tx_ready && (remain_q == LEN_ERR)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    busy     = (state != ST_IDLE);
    case (state)
      ST_SYNC: begin
        tx_valid = 1'b1;
        tx_data  = SYNC_BYTE;
      end
      ST_TAG: begin
        tx_valid = 1'b1;
        tx_data  = tag_q;
      end
      ST_DATA: begin
        tx_valid = 1'b1;
        tx_data  = payload_q[DATA_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  assign uart.tx_valid = tx_valid;
  assign uart.tx_data  = tx_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tag_q       <= '0;
      payload_q   <= '0;
      remain_q    <= '0;
      stream_en   <= 1'b0;
      stream_pend <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      if (select) begin
        tag_q     <= sel_tag;
        payload_q <= sel_payload;
        remain_q  <= sel_len;
        if (sel_cmd && (fifo_head == CMD_STREAM_ON)) stream_en <= 1'b1;
        if (sel_cmd && (fifo_head == CMD_STREAM_OFF)) stream_en <= 1'b0;
      end else if ((state == ST_DATA) && uart.tx_ready) begin
        payload_q <= payload_q >> DATA_WIDTH;
        remain_q  <= remain_q - 1'b1;
      end
      // A new request on the consuming edge re-arms pending rather than being lost.
      if (meas_valid && stream_en) begin
        stream_pend <= 1'b1;
      end else if (sel_stream) begin
        stream_pend <= 1'b0;
      end
      if ((uart.rx_valid && fifo_full) ||
          (meas_valid && stream_en && stream_pend && !sel_stream)) begin
        err_ovf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_readout_scheduler.sv
// Randomized self-checking bench: expected byte streams come from a frame-level model.
module tb_uart_readout_scheduler;
  localparam int unsigned CB = 32;
  localparam int unsigned DW = 8;
  localparam int unsigned NB = CB / DW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_valid = 1'b0;
  logic [31:0] time_high = '0;
  logic [31:0] time_low = '0;
  logic [31:0] period = '0;
  logic        busy, stream_en, err_ovf;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic       ready_level = 1'b0;
  logic       rand_ready = 1'b0;
  logic       scramble = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  int         stall_viol = 0;

  always #5 clk = ~clk;

  uart_readout_scheduler_if #(.DATA_WIDTH(DW)) bus ();

  uart_readout_scheduler #(
    .COUNTER_BITS (CB),
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (4),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart       (bus.slave),
    .meas_valid (meas_valid),
    .time_high  (time_high),
    .time_low   (time_low),
    .period     (period),
    .busy       (busy),
    .stream_en  (stream_en),
    .err_ovf    (err_ovf)
  );

  // Byte monitor: collects accepted bytes and flags any change while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!bus.tx_valid || bus.tx_data !== prev_data)) stall_viol <= stall_viol + 1;
      if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
      prev_stall <= bus.tx_valid && !bus.tx_ready;
      prev_data  <= bus.tx_data;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame model: sync, tag, then each selected word LSB-first.
  function automatic void add_frame(input logic [7:0] cmd, input bit is_stream,
                                    input logic [31:0] th, input logic [31:0] tl,
                                    input logic [31:0] per);
    logic [31:0] w[$];
    exp_q.push_back(8'hA5);
    if (is_stream || cmd == 8'h03) begin
      exp_q.push_back(is_stream ? 8'h83 : cmd);
      w.push_back(th); w.push_back(tl); w.push_back(per);
    end else if (cmd <= 8'h02) begin
      exp_q.push_back(cmd);
      w.push_back(cmd == 8'h00 ? th : (cmd == 8'h01 ? tl : per));
    end else if (cmd == 8'h04 || cmd == 8'h05) begin
      exp_q.push_back(cmd);
    end else begin
      exp_q.push_back(8'hEE);
      exp_q.push_back(cmd);
    end
    foreach (w[k]) for (int i = 0; i < NB; i++) exp_q.push_back(8'((w[k] >> (8 * i)) & 32'hFF));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    bus.tx_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_level;
    if (scramble) begin
      time_high = $urandom;
      time_low  = $urandom;
      period    = $urandom;
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_meas();
    meas_valid = 1'b1;
    step();
    meas_valid = 1'b0;
  endtask

  task automatic randomize_meas();
    time_high = $urandom;
    time_low  = $urandom;
    period    = $urandom;
  endtask

  task automatic wait_drain(output bit timeout);
    int n = 0;
    timeout = 1'b0;
    while ((got_q.size() < exp_q.size() || busy) && n < 3000) begin
      step();
      n++;
    end
    if (n >= 3000) timeout = 1'b1;
    repeat (12) step();
  endtask

  task automatic clear_queues();
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", bus.tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (stream_en !== 1'b0) begin failures++; $display("FAIL reset_stream_en got=%b exp=0", stream_en); end
    checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL reset_err_ovf got=%b exp=0", err_ovf); end
    rst_n = 1'b1;
    step();
    clear_queues();
  endtask

  task automatic test_latency();
    bit to;
    ready_level = 1'b1;
    step();
    clear_queues();
    randomize_meas();
    period = 32'h12345678;
    add_frame(8'h02, 1'b0, time_high, time_low, period);
    send_cmd(8'h02);
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) begin failures++; $display("FAIL latency_early got=%b exp=0", bus.tx_valid); end
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin
      failures++; $display("FAIL latency_sync got=%b/%h exp=1/a5", bus.tx_valid, bus.tx_data);
    end
    wait_drain(to);
    checks++; if (to) begin failures++; $display("FAIL latency_drain timeout got=%0d exp=%0d bytes", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL latency_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL latency_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_all_stall();
    bit to;
    int n = 0;
    clear_queues();
    rand_ready = 1'b1;
    randomize_meas();
    add_frame(8'h03, 1'b0, time_high, time_low, period);
    send_cmd(8'h03);
    while (got_q.size() == 0 && n < 500) begin step(); n++; end
    scramble = 1'b1;
    wait_drain(to);
    scramble = 1'b0;
    rand_ready = 1'b0;
    checks++; if (to || n >= 500) begin failures++; $display("FAIL all_drain timeout got=%0d exp=%0d bytes", got_q.size(), exp_q.size()); end
    checks++; if (stall_viol !== 0) begin failures++; $display("FAIL all_stall_stable got=%0d exp=0 violations", stall_viol); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL all_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL all_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit to;
    logic [7:0] cmds[6];
    ready_level = 1'b0;
    step();
    clear_queues();
    randomize_meas();
    for (int i = 0; i < 6; i++) begin
      int r = $urandom_range(0, 4);
      cmds[i] = (r < 4) ? 8'(r) : 8'(8'h10 + $urandom_range(0, 100));
      if (i < 5) add_frame(cmds[i], 1'b0, time_high, time_low, period);
    end
    // One command leaves the queue immediately, so depth+1 fit before a drop.
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL ovf_not_yet got=%b exp=0", err_ovf); end
      end
      bus.rx_data  = cmds[i];
      bus.rx_valid = 1'b1;
      step();
    end
    bus.rx_valid = 1'b0;
    checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", err_ovf); end
    ready_level = 1'b1;
    wait_drain(to);
    checks++; if (to) begin failures++; $display("FAIL ovf_drain timeout got=%0d exp=%0d bytes", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL ovf_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL ovf_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    test_reset();
  endtask

  task automatic test_stream();
    bit to;
    ready_level = 1'b1;
    step();
    clear_queues();
    add_frame(8'h04, 1'b0, '0, '0, '0);
    send_cmd(8'h04);
    wait_drain(to);
    checks++; if (stream_en !== 1'b1) begin failures++; $display("FAIL stream_on got=%b exp=1", stream_en); end
    for (int k = 0; k < 2; k++) begin
      randomize_meas();
      add_frame(8'h00, 1'b1, time_high, time_low, period);
      pulse_meas();
      wait_drain(to);
      checks++; if (to) begin failures++; $display("FAIL stream_drain timeout got=%0d exp=%0d bytes", got_q.size(), exp_q.size()); end
    end
    add_frame(8'h05, 1'b0, '0, '0, '0);
    send_cmd(8'h05);
    wait_drain(to);
    checks++; if (stream_en !== 1'b0) begin failures++; $display("FAIL stream_off got=%b exp=0", stream_en); end
    pulse_meas();
    repeat (40) step();
    checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL stream_err got=%b exp=0", err_ovf); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL stream_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stream_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_err_same_cycle();
    bit to;
    ready_level = 1'b1;
    step();
    clear_queues();
    add_frame(8'h7F, 1'b0, '0, '0, '0);
    send_cmd(8'h7F);
    add_frame(8'h04, 1'b0, '0, '0, '0);
    send_cmd(8'h04);
    wait_drain(to);
    randomize_meas();
    add_frame(8'h01, 1'b0, time_high, time_low, period);
    add_frame(8'h00, 1'b1, time_high, time_low, period);
    bus.rx_data  = 8'h01;
    bus.rx_valid = 1'b1;
    meas_valid   = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    meas_valid   = 1'b0;
    wait_drain(to);
    add_frame(8'h05, 1'b0, '0, '0, '0);
    send_cmd(8'h05);
    wait_drain(to);
    checks++; if (to) begin failures++; $display("FAIL same_drain timeout got=%0d exp=%0d bytes", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL same_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL same_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_pend_overrun();
    bit to;
    ready_level = 1'b1;
    step();
    clear_queues();
    randomize_meas();
    add_frame(8'h04, 1'b0, '0, '0, '0);
    send_cmd(8'h04);
    wait_drain(to);
    ready_level = 1'b0;
    step();
    add_frame(8'h00, 1'b1, time_high, time_low, period);
    add_frame(8'h00, 1'b1, time_high, time_low, period);
    pulse_meas();
    repeat (3) step();
    pulse_meas();
    checks++; if (err_ovf !== 1'b0) begin failures++; $display("FAIL pend_first got=%b exp=0", err_ovf); end
    repeat (2) step();
    pulse_meas();
    checks++; if (err_ovf !== 1'b1) begin failures++; $display("FAIL pend_overrun got=%b exp=1", err_ovf); end
    ready_level = 1'b1;
    wait_drain(to);
    checks++; if (to) begin failures++; $display("FAIL pend_drain timeout got=%0d exp=%0d bytes", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL pend_len got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL pend_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
    end
    test_reset();
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    int held;
    logic [7:0] cmds[6] = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    ready_level = 1'b1;
    step();
    clear_queues();
    add_frame(8'h04, 1'b0, '0, '0, '0);
    send_cmd(8'h04);
    wait_drain(to);
    ready_level = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      bus.rx_data  = cmds[i];
      bus.rx_valid = 1'b1;
      step();
    end
    bus.rx_valid = 1'b0;
    checks++; if (err_ovf !== 1'b1 || stream_en !== 1'b1) begin
      failures++; $display("FAIL rstmid_setup got=%b/%b exp=1/1", err_ovf, stream_en);
    end
    got_q.delete();
    ready_level = 1'b1;
    while (got_q.size() < 4 && n < 200) begin step(); n++; end
    rst_n = 1'b0;
    step();
    held = got_q.size();
    checks++; if (n >= 200) begin failures++; $display("FAIL rstmid_wait timeout got=%0d exp=4 bytes", got_q.size()); end
    checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rstmid_idle got=%b/%b exp=0/0", bus.tx_valid, busy);
    end
    checks++; if (stream_en !== 1'b0 || err_ovf !== 1'b0) begin
      failures++; $display("FAIL rstmid_flags got=%b/%b exp=0/0", stream_en, err_ovf);
    end
    repeat (2) step();
    rst_n = 1'b1;
    repeat (40) step();
    checks++; if (got_q.size() !== held) begin failures++; $display("FAIL rstmid_quiet got=%0d exp=%0d bytes", got_q.size(), held); end
  endtask

  initial begin
    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b0;
    test_reset();
    test_latency();
    test_all_stall();
    test_overflow();
    test_stream();
    test_err_same_cycle();
    test_pend_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
